// File: rtl/time_settings_pkg.sv
// time_settings: shared types and defaults for emulated-clock timing logic.
//   time_t        : emulator time value
//   inc_t         : period increment at the default INC_BITS width
//   LFSR_SEED_DEF : default nonzero seed for the jitter LFSR
package time_settings;

  localparam int          INC_BITS_DEF  = 16;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  typedef logic [63:0]             time_t;
  typedef logic [INC_BITS_DEF-1:0] inc_t;

endpackage

// File: rtl/clock_period_gen_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, taps 16,14,13,11, used as the jitter source.
// Ports:
//   clk_sys : system clock
//   rst_n   : synchronous active-low reset, loads seed
//   step    : advance the LFSR by one state this cycle
//   seed    : reset value (must be nonzero)
//   state   : current LFSR state
//   next    : state the LFSR moves to on the next step
module lfsr16
  import time_settings::*;
(
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] state,
  output logic [15:0] next
);

  logic [15:0] state_q;

  assign next  = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
  assign state = state_q;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q <= seed;
    end else if (step) begin
      state_q <= next;
    end
  end

endmodule

// File: rtl/clock_period_gen.sv
// clock_period_gen: produces the per-edge period increment for one emulated
// clock: nominal period + fractional carry + optional LFSR jitter, clamped to
// [1, 2^INC_BITS-1]. Advances only when the downstream stage consumes an edge.
// Ports:
//   clk_sys, rst_n      : clock, synchronous active-low reset
//   advance             : current inc consumed this cycle (time_eq)
//   cfg_we              : load shadow config from cfg_period_nom/frac/jitter_en
//   cfg_period_nom      : nominal integer period
//   cfg_period_frac     : fractional period in 2^-FRAC_BITS units
//   cfg_jitter_en       : enable the signed jitter term
//   inc                 : registered period increment, never 0
//   edge_count          : consumed edges, wraps modulo 2^32
//   sat                 : sticky, set when a period was clamped
module clock_period_gen
  import time_settings::*;
#(
  parameter int          INC_BITS    = INC_BITS_DEF,
  parameter int          FRAC_BITS   = 8,
  parameter int          JITTER_BITS = 4,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF,
  parameter int          INC_RESET   = 16
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic                 advance,
  input  logic                 cfg_we,
  input  logic [INC_BITS-1:0]  cfg_period_nom,
  input  logic [FRAC_BITS-1:0] cfg_period_frac,
  input  logic                 cfg_jitter_en,
  output logic [INC_BITS-1:0]  inc,
  output logic [31:0]          edge_count,
  output logic                 sat
);

  // Two guard bits cover both the negative jitter range and nom+carry+jitter
  // overflowing the INC_BITS range.
  localparam int S_W = INC_BITS + 2;
  localparam logic [INC_BITS-1:0]  INC_RST_V = INC_RESET[INC_BITS-1:0];
  localparam logic signed [S_W-1:0] MIN_S = {{(S_W-1){1'b0}}, 1'b1};
  localparam logic signed [S_W-1:0] MAX_S = {2'b00, {INC_BITS{1'b1}}};

  logic [INC_BITS-1:0]  sh_nom_q, a_nom_q, inc_q;
  logic [FRAC_BITS-1:0] sh_frac_q, a_frac_q, acc_q;
  logic                 sh_jit_q, a_jit_q, sat_q;
  logic [31:0]          edge_count_q;

  logic [INC_BITS-1:0]  eff_nom;
  logic [FRAC_BITS-1:0] eff_frac;
  logic                 eff_jit;
  logic [FRAC_BITS:0]   frac_sum;
  logic [15:0]          lfsr_state, lfsr_next;
  logic signed [S_W-1:0] jit_s, sum_s;
  logic [INC_BITS:0]    clamp_res;
  logic                 unused_ok;

  // Returns {clamped, value} with value limited to [1, 2^INC_BITS-1].
  function automatic logic [INC_BITS:0] clamp_inc(input logic signed [S_W-1:0] s);
    if (s < MIN_S) begin
      return {1'b1, {{(INC_BITS-1){1'b0}}, 1'b1}};
    end else if (s > MAX_S) begin
      return {1'b1, {INC_BITS{1'b1}}};
    end else begin
      return {1'b0, s[INC_BITS-1:0]};
    end
  endfunction

  lfsr16 u_lfsr (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .step    (advance),
    .seed    (LFSR_SEED),
    .state   (lfsr_state),
    .next    (lfsr_next)
  );

  // Config in force for this advance: a coincident write bypasses the shadow.
  assign eff_nom  = cfg_we ? cfg_period_nom  : sh_nom_q;
  assign eff_frac = cfg_we ? cfg_period_frac : sh_frac_q;
  assign eff_jit  = cfg_we ? cfg_jitter_en   : sh_jit_q;

  assign frac_sum = {1'b0, acc_q} + {1'b0, eff_frac};

  // Jitter uses the post-step LFSR value, sign-extended from JITTER_BITS.
  assign jit_s = eff_jit
               ? {{(S_W-JITTER_BITS){lfsr_next[JITTER_BITS-1]}}, lfsr_next[JITTER_BITS-1:0]}
               : '0;

  assign sum_s = $signed({2'b00, eff_nom})
               + $signed({{(S_W-1){1'b0}}, frac_sum[FRAC_BITS]})
               + jit_s;

  assign clamp_res = clamp_inc(sum_s);

  // Active config and raw LFSR state are held for observation only.
  assign unused_ok = ^{lfsr_state, lfsr_next, a_nom_q, a_frac_q, a_jit_q};

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      sh_nom_q     <= INC_RST_V;
      sh_frac_q    <= '0;
      sh_jit_q     <= 1'b0;
      a_nom_q      <= INC_RST_V;
      a_frac_q     <= '0;
      a_jit_q      <= 1'b0;
      acc_q        <= '0;
      inc_q        <= INC_RST_V;
      edge_count_q <= '0;
      sat_q        <= 1'b0;
    end else begin
      if (cfg_we) begin
        sh_nom_q  <= cfg_period_nom;
        sh_frac_q <= cfg_period_frac;
        sh_jit_q  <= cfg_jitter_en;
      end
      if (advance) begin
        a_nom_q      <= eff_nom;
        a_frac_q     <= eff_frac;
        a_jit_q      <= eff_jit;
        acc_q        <= frac_sum[FRAC_BITS-1:0];
        inc_q        <= clamp_res[INC_BITS-1:0];
        edge_count_q <= edge_count_q + 32'd1;
        if (clamp_res[INC_BITS]) begin
          sat_q <= 1'b1;
        end
      end
    end
  end

  assign inc        = inc_q;
  assign edge_count = edge_count_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_clock_period_gen.sv
module tb_clock_period_gen;

  localparam int FRAC_BITS = 8;
  localparam int JB        = 4;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        advance = 1'b0;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_period_nom = '0;
  logic [7:0]  cfg_period_frac = '0;
  logic        cfg_jitter_en = 1'b0;
  logic [15:0] inc;
  logic [31:0] edge_count;
  logic        sat;

  int total = 0;
  int bad   = 0;

  // Reference model state (spec-level, plain integers)
  int     m_sh_nom, m_sh_frac, m_a_nom, m_a_frac;
  bit     m_sh_jit, m_a_jit, m_sat;
  int     m_acc, m_lfsr, m_inc;
  longint m_cnt;

  clock_period_gen dut (
    .clk_sys         (clk_sys),
    .rst_n           (rst_n),
    .advance         (advance),
    .cfg_we          (cfg_we),
    .cfg_period_nom  (cfg_period_nom),
    .cfg_period_frac (cfg_period_frac),
    .cfg_jitter_en   (cfg_jitter_en),
    .inc             (inc),
    .edge_count      (edge_count),
    .sat             (sat)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lfsr_step(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 'hFFFF;
  endfunction

  task automatic model_edge(input bit r, input bit adv, input bit we,
                            input int nom, input int frac, input bit jit);
    int tot, carry, j, s;
    if (!r) begin
      m_sh_nom = 16; m_sh_frac = 0; m_sh_jit = 0;
      m_a_nom = 16;  m_a_frac = 0;  m_a_jit = 0;
      m_acc = 0; m_lfsr = 'hACE1; m_inc = 16; m_cnt = 0; m_sat = 0;
    end else begin
      if (we) begin
        m_sh_nom = nom; m_sh_frac = frac; m_sh_jit = jit;
      end
      if (adv) begin
        m_a_nom = m_sh_nom; m_a_frac = m_sh_frac; m_a_jit = m_sh_jit;
        tot    = m_acc + m_a_frac;
        carry  = tot / (1 << FRAC_BITS);
        m_acc  = tot % (1 << FRAC_BITS);
        m_lfsr = lfsr_step(m_lfsr);
        j = 0;
        if (m_a_jit) begin
          j = m_lfsr % (1 << JB);
          if (j >= (1 << (JB - 1))) j -= (1 << JB);
        end
        s = m_a_nom + carry + j;
        if (s < 1) begin
          m_inc = 1; m_sat = 1;
        end else if (s > 65535) begin
          m_inc = 65535; m_sat = 1;
        end else begin
          m_inc = s;
        end
        m_cnt = (m_cnt + 1) % 64'h1_0000_0000;
      end
    end
  endtask

  // One clock: drive inputs away from the edge, update model at the edge,
  // then settle 1 time unit past the edge for sampling.
  task automatic cyc(input bit r, input bit adv, input bit we,
                     input int nom = 0, input int frac = 0, input bit jit = 0);
    rst_n           = r;
    advance         = adv;
    cfg_we          = we;
    cfg_period_nom  = 16'(nom);
    cfg_period_frac = 8'(frac);
    cfg_jitter_en   = jit;
    @(posedge clk_sys);
    model_edge(r, adv, we, nom, frac, jit);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_inc"}, 32'(inc), 32'(m_inc));
    check({tag, "_cnt"}, edge_count, m_cnt[31:0]);
    check({tag, "_sat"}, 32'(sat), 32'(m_sat));
  endtask

  int exp_seq [8] = '{10, 10, 10, 11, 10, 10, 10, 11};

  initial begin
    bit found;
    bit zero_seen;
    int lfsr_before;
    int pick_nom;

    // Reset state
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("rst_inc", 32'(inc), 32'd16);
    check("rst_cnt", edge_count, 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_acc", 32'(dut.acc_q), 32'd0);
    check("rst_lfsr", 32'(dut.u_lfsr.state_q), 32'hACE1);

    // Four advances at default config
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0);
      check("dflt_inc", 32'(inc), 32'd16);
    end
    check("dflt_cnt", edge_count, 32'd4);
    check("dflt_sat", 32'(sat), 32'd0);

    // Fractional period: nom=10, frac=0x40
    cyc(1, 0, 1, 10, 'h40, 0);
    check("frac_hold_inc", 32'(inc), 32'd16);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0);
      check("frac_seq", 32'(inc), 32'(exp_seq[i]));
      check_all("frac_mdl");
    end

    // Low clamp: apply nom=3 with jitter exactly when jitter will be -8
    cyc(0, 0, 0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if ((lfsr_step(m_lfsr) % 16) == 8) begin
        cyc(1, 1, 1, 3, 0, 1);
        found = 1;
        check("clamp_lo_inc", 32'(inc), 32'd1);
        check("clamp_lo_sat", 32'(sat), 32'd1);
      end else begin
        cyc(1, 1, 0);
        check_all("pre_lo");
      end
    end
    check("clamp_lo_found", 32'(found), 32'd1);

    // High clamp: nom=0xFFFE with jitter +7
    cyc(0, 0, 0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if ((lfsr_step(m_lfsr) % 16) == 7) begin
        cyc(1, 1, 1, 'hFFFE, 0, 1);
        found = 1;
        check("clamp_hi_inc", 32'(inc), 32'hFFFF);
        check("clamp_hi_sat", 32'(sat), 32'd1);
      end else begin
        cyc(1, 1, 0);
        check_all("pre_hi");
      end
    end
    check("clamp_hi_found", 32'(found), 32'd1);

    // Coincident cfg_we and advance, then a long idle stretch
    cyc(1, 1, 1, 20, 0, 0);
    check("coinc_inc", 32'(inc), 32'd20);
    lfsr_before = m_lfsr;
    for (int i = 0; i < 50; i++) begin
      cyc(1, 0, 0);
      check("idle_inc", 32'(inc), 32'd20);
    end
    check("idle_lfsr", 32'(dut.u_lfsr.state_q), 32'(lfsr_before));
    check_all("idle_mdl");

    // Full LFSR period with jitter enabled
    cyc(0, 0, 0);
    cyc(1, 0, 1, 16, 0, 1);
    zero_seen = 0;
    for (int i = 0; i < 65535; i++) begin
      cyc(1, 1, 0);
      if (dut.u_lfsr.state_q == 16'h0) zero_seen = 1;
      check("period_inc", 32'(inc), 32'(m_inc));
    end
    check("period_lfsr", 32'(dut.u_lfsr.state_q), 32'hACE1);
    check("period_nonzero", 32'(zero_seen), 32'd0);
    check_all("period_mdl");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       pick_nom = int'($urandom_range(0, 4));
        1:       pick_nom = int'($urandom_range(65530, 65535));
        default: pick_nom = int'($urandom_range(0, 65535));
      endcase
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 4) == 0), pick_nom,
          int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
      check_all("rand");
      check("rand_lfsr", 32'(dut.u_lfsr.state_q), 32'(m_lfsr));
    end

    // Reset overrides coincident advance and config write
    cyc(1, 1, 0);
    cyc(0, 1, 1, 99, 'h80, 1);
    check("rstov_inc", 32'(inc), 32'd16);
    check("rstov_acc", 32'(dut.acc_q), 32'd0);
    check("rstov_cnt", edge_count, 32'd0);
    check("rstov_sat", 32'(sat), 32'd0);
    cyc(1, 1, 0);
    check("rstov_nocfg_inc", 32'(inc), 32'd16);
    check("rstov_nocfg_cnt", edge_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
